// File: rtl/mod_sched_pkg.sv
// Shared types and defaults for the modulator frame scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mod_sched_pkg;

  // Scheduler FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } sched_state_t;

  // Default geometry: 128-bit frames, 4 clk per bit, 8 idle cycles per frame.
  localparam int FRAME_BITS_DEF = 128;
  localparam int BIT_DIV_DEF    = 4;
  localparam int GAP_CYC_DEF    = 8;

  // Bits per 16QAM symbol.
  localparam int SYM_BITS = 4;

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mod_frame_sched_rr_arb2.sv
// Two-way round-robin arbiter: picks one of two requesters, favouring the one
// not granted last when both ask. Latency: purely combinational, 0 cycles.
// Backpressure: grants only while advance is high; otherwise gnt is all zero.
//
// Ports:
//   req[1:0]   request lines, bit n = requester n
//   advance    arbiter may grant this cycle
//   last_grant id of the previously granted requester
//   gnt[1:0]   one-hot grant (zero when idle or not advancing)
//   gnt_id     id of the winning requester (meaningful when any req is set)
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       advance,
  input  logic       last_grant,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  always_comb begin
    gnt_id = 1'b0;
    if (req == 2'b11) begin
      // Tie: the requester that did not win last time goes next.
      gnt_id = ~last_grant;
    end else if (req == 2'b10) begin
      gnt_id = 1'b1;
    end

    gnt = 2'b00;
    if (advance && (|req)) begin
      gnt = gnt_id ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/mod_frame_sched.sv
// Frame scheduler: round-robin grant of two frame sources, MSB-first serialiser with bit/symbol strobes.
// Latency: transfer on cycle T puts the first bit (with mod_en and both strobes) out on cycle T+1.
// Backpressure: readies only rise in IDLE, one requester at a time; requesters hold valid until ready.
//
// Ports:
//   clk, reset               single clock, asynchronous active-high reset
//   req0_valid/data/ready    payload source handshake (frame MSB sent first)
//   req1_valid/data/ready    pilot/preamble source handshake
//   serial_data              serial bit to the modulator (registered)
//   mod_en                   high for every cycle of a frame in flight (registered)
//   bit_strobe, sym_strobe   first clk of each bit / each 4-bit symbol (registered)
//   grant_id                 source of the current or most recent frame
//   frame_done               one-cycle pulse coincident with a frame's last clk
module mod_frame_sched
  import mod_sched_pkg::*;
#(
  parameter int FRAME_BITS = FRAME_BITS_DEF,
  parameter int BIT_DIV    = BIT_DIV_DEF,
  parameter int GAP_CYC    = GAP_CYC_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  input  logic [FRAME_BITS-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [FRAME_BITS-1:0] req1_data,
  output logic                  req1_ready,
  output logic                  serial_data,
  output logic                  mod_en,
  output logic                  bit_strobe,
  output logic                  sym_strobe,
  output logic                  grant_id,
  output logic                  frame_done
);

  localparam int BW        = cnt_width(FRAME_BITS);
  localparam int DW        = cnt_width(BIT_DIV);
  localparam int GW        = cnt_width(GAP_CYC);
  localparam int SYM_IDX_W = $clog2(SYM_BITS);

  localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(BIT_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  sched_state_t          state;
  logic [FRAME_BITS-1:0] shreg;
  logic [BW-1:0]         bit_cnt;
  logic [DW-1:0]         div_cnt;
  logic [GW-1:0]         gap_cnt;
  logic                  last_grant;

  // Arbitration
  logic [1:0]            gnt;
  logic                  arb_id;
  logic                  xfer;
  logic [FRAME_BITS-1:0] sel_data;

  // Reset is folded in so the readies read 0 while reset is held.
  rr_arb2 u_arb (
    .req        ({req1_valid, req0_valid}),
    .advance    ((state == IDLE) && !reset),
    .last_grant (last_grant),
    .gnt        (gnt),
    .gnt_id     (arb_id)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign xfer       = |gnt;
  assign sel_data   = arb_id ? req1_data : req0_data;

  // Next-count lookahead. The strobes and frame_done are registered, so they
  // are computed from where the counters will be on the following cycle.
  logic                  div_wrap;
  logic                  frame_end;
  logic [BW-1:0]         bit_nxt;
  logic [DW-1:0]         div_nxt;
  logic [FRAME_BITS-1:0] shreg_nxt;

  always_comb begin
    div_wrap  = (div_cnt == DIV_LAST);
    frame_end = (bit_cnt == BIT_LAST) && div_wrap;
    bit_nxt   = div_wrap ? bit_cnt + 1'b1 : bit_cnt;
    div_nxt   = div_wrap ? '0 : div_cnt + 1'b1;
    shreg_nxt = {shreg[FRAME_BITS-2:0], 1'b0};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      div_cnt     <= '0;
      gap_cnt     <= '0;
      last_grant  <= 1'b1;
      grant_id    <= 1'b0;
      serial_data <= 1'b0;
      mod_en      <= 1'b0;
      bit_strobe  <= 1'b0;
      sym_strobe  <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      bit_strobe <= 1'b0;
      sym_strobe <= 1'b0;
      frame_done <= 1'b0;

      case (state)
        IDLE: begin
          serial_data <= 1'b0;
          mod_en      <= 1'b0;
          if (xfer) begin
            shreg       <= sel_data;
            grant_id    <= arb_id;
            last_grant  <= arb_id;
            bit_cnt     <= '0;
            div_cnt     <= '0;
            serial_data <= sel_data[FRAME_BITS-1];
            mod_en      <= 1'b1;
            bit_strobe  <= 1'b1;
            sym_strobe  <= 1'b1;
            state       <= SEND;
          end
        end

        SEND: begin
          if (frame_end) begin
            serial_data <= 1'b0;
            mod_en      <= 1'b0;
            gap_cnt     <= '0;
            state       <= (GAP_CYC == 0) ? IDLE : GAP;
          end else begin
            div_cnt <= div_nxt;
            bit_cnt <= bit_nxt;
            if (div_wrap) begin
              shreg       <= shreg_nxt;
              serial_data <= shreg_nxt[FRAME_BITS-1];
              bit_strobe  <= 1'b1;
              sym_strobe  <= (bit_nxt[SYM_IDX_W-1:0] == '0);
            end
            // Raised one cycle early so the pulse lands on the last clk.
            frame_done <= (bit_nxt == BIT_LAST) && (div_nxt == DIV_LAST);
          end
        end

        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_frame_sched.sv
// Self-checking bench for mod_frame_sched: default geometry plus an 8-bit/1-div/no-gap corner.
// Latency: n/a. Backpressure: requesters hold valid until ready.
// Outputs are sampled on the falling clock edge; inputs are driven there too.
module tb_mod_frame_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- DUT A: 128 bits, 4 clk/bit, 8 gap cycles ----------------
  logic         rst_a;
  logic         a_v0, a_v1, a_r0, a_r1;
  logic [127:0] a_d0, a_d1;
  logic         a_ser, a_mod, a_bs, a_ss, a_gid, a_fd;

  mod_frame_sched #(.FRAME_BITS(128), .BIT_DIV(4), .GAP_CYC(8)) dut_a (
    .clk(clk), .reset(rst_a),
    .req0_valid(a_v0), .req0_data(a_d0), .req0_ready(a_r0),
    .req1_valid(a_v1), .req1_data(a_d1), .req1_ready(a_r1),
    .serial_data(a_ser), .mod_en(a_mod), .bit_strobe(a_bs), .sym_strobe(a_ss),
    .grant_id(a_gid), .frame_done(a_fd)
  );

  // ---------------- DUT B: 8 bits, 1 clk/bit, no gap ----------------
  logic       rst_b;
  logic       b_v0, b_v1, b_r0, b_r1;
  logic [7:0] b_d0, b_d1;
  logic       b_ser, b_mod, b_bs, b_ss, b_gid, b_fd;

  mod_frame_sched #(.FRAME_BITS(8), .BIT_DIV(1), .GAP_CYC(0)) dut_b (
    .clk(clk), .reset(rst_b),
    .req0_valid(b_v0), .req0_data(b_d0), .req0_ready(b_r0),
    .req1_valid(b_v1), .req1_data(b_d1), .req1_ready(b_r1),
    .serial_data(b_ser), .mod_en(b_mod), .bit_strobe(b_bs), .sym_strobe(b_ss),
    .grant_id(b_gid), .frame_done(b_fd)
  );

  // Observations collected over one DUT A frame.
  typedef struct {
    int           wt;          // sampled cycles with mod_en low before the frame
    int           nmod;        // cycles with mod_en high
    int           nbs, nss;    // strobe counts
    int           nfd, fd_idx; // frame_done count and its mod_en cycle index
    int           glitch;      // serial changes away from a bit boundary
    int           sym_bad;     // sym_strobe not on a 4-bit boundary
    int           sym_gap_bad; // sym_strobe spacing other than 16
    int           rdy_frame;   // ready seen while mod_en high
    int           rdy_wait;    // ready seen before the frame
    logic [127:0] word;        // bits sampled on each bit_strobe, MSB first
    logic         first_bs, first_ss, gid, fd_after;
  } cap_t;

  // Wait (bounded) for the next A frame and observe it until mod_en falls.
  // On the frame's first cycle the valids are set to v0_after/v1_after; req1
  // is raised on mod_en cycle raise1_at (negative: never).
  task automatic cap_a(input int raise1_at, input logic v0_after, input logic v1_after,
                       output cap_t r);
    logic prev;
    int   last_ss;
    r = '{default: 0};
    r.fd_idx = -1;
    prev = 1'b0;
    last_ss = -1;
    #1;
    while (!a_mod && r.wt < 3000) begin
      if (a_r0 || a_r1) r.rdy_wait++;
      if (a_fd) r.nfd++;
      r.wt++;
      @(negedge clk);
    end
    while (a_mod && r.nmod < 3000) begin
      if (r.nmod == 0) begin
        r.first_bs = a_bs;
        r.first_ss = a_ss;
        r.gid = a_gid;
        a_v0 = v0_after;
        a_v1 = v1_after;
      end
      if (r.nmod == raise1_at) a_v1 = 1'b1;
      if (a_r0 || a_r1) r.rdy_frame++;
      if (a_bs) begin
        r.nbs++;
        r.word = {r.word[126:0], a_ser};
      end else if (a_ser !== prev) begin
        r.glitch++;
      end
      if (a_ss) begin
        r.nss++;
        if (!a_bs || ((r.nbs - 1) % 4) != 0) r.sym_bad++;
        if (last_ss >= 0 && (r.nmod - last_ss) != 16) r.sym_gap_bad++;
        last_ss = r.nmod;
      end
      if (a_fd) begin
        r.nfd++;
        r.fd_idx = r.nmod;
      end
      prev = a_ser;
      r.nmod++;
      @(negedge clk);
    end
    r.fd_after = a_fd;
  endtask

  // Returns on the falling edge where reset is released.
  task automatic reset_a();
    @(negedge clk);
    rst_a = 1'b1;
    a_v0 = 1'b0;
    a_v1 = 1'b0;
    repeat (2) @(negedge clk);
    rst_a = 1'b0;
  endtask

  // Table for DUT B: one frame per record, applied back to back.
  typedef struct {
    logic       v0, v1;
    logic [7:0] d0, d1;
    logic [1:0] exp_rdy;   // {req1_ready, req0_ready}
    logic       exp_gid;
    logic [7:0] exp_bits;  // serial_data over the 8 frame cycles, first bit in MSB
  } vec_t;

  vec_t vt [7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    cap_t         r;
    logic [127:0] w0, w1;
    logic [7:0]   bits, ss, fd, mod, bs;
    logic         gid;
    int           fd_seen;

    rst_a = 1'b1; rst_b = 1'b1;
    a_v0 = 1'b1; a_v1 = 1'b1; a_d0 = '1; a_d1 = '1;
    b_v0 = 1'b0; b_v1 = 1'b0; b_d0 = '0; b_d1 = '0;

    // last_grant starts at 1, so the first tie goes to requester 0.
    vt[0] = '{1'b1, 1'b0, 8'hA5, 8'h00, 2'b01, 1'b0, 8'hA5};
    vt[1] = '{1'b1, 1'b1, 8'h3C, 8'hC3, 2'b10, 1'b1, 8'hC3};
    vt[2] = '{1'b1, 1'b1, 8'h0F, 8'hF0, 2'b01, 1'b0, 8'h0F};
    vt[3] = '{1'b0, 1'b1, 8'h00, 8'h81, 2'b10, 1'b1, 8'h81};
    vt[4] = '{1'b0, 1'b1, 8'h00, 8'h7E, 2'b10, 1'b1, 8'h7E};
    vt[5] = '{1'b1, 1'b1, 8'h5A, 8'hFF, 2'b01, 1'b0, 8'h5A};
    vt[6] = '{1'b1, 1'b0, 8'h00, 8'h99, 2'b01, 1'b0, 8'h00};

    // ---- Reset state (valids high on A while reset is held) ----
    repeat (3) @(negedge clk);
    chk("reset_regs_a", {a_ser, a_mod, a_bs, a_ss, a_fd, a_gid}, 6'b0);
    chk("reset_ready_a", {a_r1, a_r0}, 2'b00);
    chk("reset_regs_b", {b_ser, b_mod, b_bs, b_ss, b_fd, b_gid, b_r1, b_r0}, 8'b0);

    // ---- Corner geometry: table of back-to-back 8-bit frames ----
    rst_b = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      b_v0 = vt[i].v0; b_v1 = vt[i].v1; b_d0 = vt[i].d0; b_d1 = vt[i].d1;
      #1;
      chk($sformatf("b%0d_ready", i), {b_r1, b_r0}, vt[i].exp_rdy);
      @(negedge clk);
      b_v0 = 1'b0; b_v1 = 1'b0;
      gid = b_gid;
      bits = '0; ss = '0; fd = '0; mod = '0; bs = '0;
      for (int k = 0; k < 8; k++) begin
        bits = {bits[6:0], b_ser};
        ss   = {ss[6:0], b_ss};
        fd   = {fd[6:0], b_fd};
        mod  = {mod[6:0], b_mod};
        bs   = {bs[6:0], b_bs};
        @(negedge clk);
      end
      chk($sformatf("b%0d_gid", i), gid, vt[i].exp_gid);
      chk($sformatf("b%0d_serial", i), bits, vt[i].exp_bits);
      chk($sformatf("b%0d_mod_en", i), mod, 8'hFF);
      chk($sformatf("b%0d_bit_strobe", i), bs, 8'hFF);
      chk($sformatf("b%0d_sym_strobe", i), ss, 8'b1000_1000);
      chk($sformatf("b%0d_frame_done", i), fd, 8'b0000_0001);
      // Exactly one idle cycle before the next record's transfer.
      chk($sformatf("b%0d_idle", i), {b_mod, b_fd}, 2'b00);
    end

    // ---- A: single frame 8000...0001 ----
    reset_a();
    a_d0 = {1'b1, 126'b0, 1'b1};
    a_v0 = 1'b1;
    #1;
    chk("single_ready", {a_r1, a_r0}, 2'b01);
    cap_a(-1, 1'b0, 1'b0, r);
    chk("single_latency", r.wt, 1);
    chk("single_first_strobes", {r.first_bs, r.first_ss}, 2'b11);
    chk("single_mod_cycles", r.nmod, 512);
    chk("single_word", r.word, {1'b1, 126'b0, 1'b1});
    chk("single_glitch", r.glitch, 0);
    chk("single_fd_count", r.nfd, 1);
    chk("single_fd_index", r.fd_idx, 511);
    chk("single_fd_after", r.fd_after, 1'b0);
    chk("single_gid", r.gid, 1'b0);
    chk("single_ready_in_frame", r.rdy_frame, 0);

    // ---- A: strobe counting with F0F0... (offered during the gap) ----
    a_d0 = {16{8'hF0}};
    a_v0 = 1'b1;
    cap_a(-1, 1'b0, 1'b0, r);
    chk("strobe_wait", r.wt, 9);
    chk("strobe_ready_wait", r.rdy_wait, 1);
    chk("strobe_bit_count", r.nbs, 128);
    chk("strobe_sym_count", r.nss, 32);
    chk("strobe_sym_align", r.sym_bad, 0);
    chk("strobe_sym_spacing", r.sym_gap_bad, 0);
    chk("strobe_word", r.word, {16{8'hF0}});

    // ---- A: both valids held from reset ----
    reset_a();
    w0 = {8{16'h1111}};
    w1 = {8{16'h2222}};
    a_d0 = w0; a_d1 = w1; a_v0 = 1'b1; a_v1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cap_a(-1, 1'b1, 1'b1, r);
      chk($sformatf("rr%0d_gid", k), r.gid, (k % 2 == 1) ? 1'b1 : 1'b0);
      chk($sformatf("rr%0d_word", k), r.word, (k % 2 == 1) ? w1 : w0);
      chk($sformatf("rr%0d_wait", k), r.wt, (k == 0) ? 1 : 9);
      chk($sformatf("rr%0d_ready_wait", k), r.rdy_wait, 1);
      chk($sformatf("rr%0d_ready_frame", k), r.rdy_frame, 0);
    end

    // ---- A: stall fairness, req1 arrives mid-frame, req0 re-asserts at once ----
    reset_a();
    a_d0 = {4{32'hDEAD_BEEF}};
    a_d1 = {4{32'h0123_4567}};
    a_v0 = 1'b1;
    cap_a(200, 1'b1, 1'b0, r);
    chk("stall0_gid", r.gid, 1'b0);
    chk("stall0_ready_frame", r.rdy_frame, 0);
    cap_a(-1, 1'b1, 1'b0, r);
    chk("stall1_gid", r.gid, 1'b1);
    chk("stall1_word", r.word, {4{32'h0123_4567}});
    chk("stall1_wait", r.wt, 9);
    chk("stall1_ready_wait", r.rdy_wait, 1);
    chk("stall1_ready_frame", r.rdy_frame, 0);
    cap_a(-1, 1'b0, 1'b0, r);
    chk("stall2_gid", r.gid, 1'b0);
    chk("stall2_word", r.word, {4{32'hDEAD_BEEF}});

    // ---- A: reset asserted at bit 60 ----
    reset_a();
    a_d0 = '1;
    a_v0 = 1'b1;
    #1;
    chk("midrst_ready", {a_r1, a_r0}, 2'b01);
    @(negedge clk);
    a_v0 = 1'b0;
    fd_seen = 0;
    repeat (240) begin
      if (a_fd) fd_seen++;
      @(negedge clk);
    end
    chk("midrst_bit60", {a_mod, a_ser}, 2'b11);
    rst_a = 1'b1;
    a_v1 = 1'b1;
    a_d1 = {8{16'hC33C}};
    #1;
    chk("midrst_async_zero", {a_ser, a_mod, a_bs, a_ss, a_fd, a_gid, a_r1, a_r0}, 8'b0);
    repeat (3) begin
      @(negedge clk);
      if (a_fd) fd_seen++;
    end
    chk("midrst_no_frame_done", fd_seen, 0);
    rst_a = 1'b0;
    #1;
    chk("midrst_accept", {a_r1, a_r0}, 2'b10);
    cap_a(-1, 1'b0, 1'b0, r);
    chk("midrst_wait", r.wt, 1);
    chk("midrst_gid", r.gid, 1'b1);
    chk("midrst_word", r.word, {8{16'hC33C}});
    chk("midrst_fd_count", r.nfd, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
